// File: rtl/vmicro16_uart_rx_apb.sv
// vmicro16_uart_rx_apb: APB slave UART receiver.
//   Two-flop synchronises rx_wire, deframes 8N1 characters (8E1 when the
//   UART_RX_PARITY_EN macro is defined) into an RX FIFO, and exposes
//   DATA / STATUS / CLKDIV registers on a zero-wait-state APB slave port.
// Ports:
//   clk, reset      system clock, asynchronous active-low reset
//   S_PADDR..S_PWDATA  APB request (only S_PADDR[1:0] decoded)
//   S_PRDATA, S_PREADY shared read-data / ready, driven only while S_PSELx
//   rx_wire         asynchronous serial input, idle high
//   irq             registered, high while the FIFO holds data
// Optional feature macro: UART_RX_PARITY_EN (even parity bit after bit 7).
module vmicro16_uart_rx_apb #(
  parameter int unsigned BUS_WIDTH    = 16,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] S_PADDR,
  input  logic                 S_PWRITE,
  input  logic                 S_PSELx,
  input  logic                 S_PENABLE,
  input  logic [BUS_WIDTH-1:0] S_PWDATA,
  inout  wire  [BUS_WIDTH-1:0] S_PRDATA,
  inout  wire                  S_PREADY,
  input  logic                 rx_wire,
  output logic                 irq
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned MIN_DIV = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [BUS_WIDTH-1:0] cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0] div_q, div_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic                 rx_meta_q, rx_sync_q;
  logic [BUS_WIDTH-1:0] clkdiv_q;
  logic                 overrun_q, frame_q, parity_q;
  logic                 irq_q;

  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;

  logic                 expire_c, push_c, pop_c, full_c, not_empty_c;
  logic                 overrun_set_c, frame_set_c, parity_set_c;
  logic                 access_c, w1c_c, clkdiv_wr_c;
  logic [1:0]           addr_c;
  logic [15:0]          status_c;
  logic [BUS_WIDTH-1:0] rdata_c;
  logic                 unused_c;

  assign unused_c = ^S_PADDR[BUS_WIDTH-1:2];

  // APB decode; side effects only on the access-phase edge
  assign addr_c      = S_PADDR[1:0];
  assign access_c    = S_PSELx & S_PENABLE;
  assign not_empty_c = (count_q != CNT_W'(0));
  assign full_c      = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop_c       = access_c & ~S_PWRITE & (addr_c == 2'd0) & not_empty_c;
  assign w1c_c       = access_c & S_PWRITE & (addr_c == 2'd1);
  assign clkdiv_wr_c = access_c & S_PWRITE & (addr_c == 2'd2);

  // Input synchroniser, resets to the idle (high) line level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_wire;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receiver FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Loading N into the counter yields a sample N cycles later
  assign expire_c = (cnt_q <= BUS_WIDTH'(1));

  // Receiver FSM next-state; div_q freezes CLKDIV for the whole frame
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    div_d         = div_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    push_c        = 1'b0;
    overrun_set_c = 1'b0;
    frame_set_c   = 1'b0;
    parity_set_c  = 1'b0;
    if (state_q != ST_IDLE && !expire_c) cnt_d = cnt_q - BUS_WIDTH'(1);
    case (state_q)
      ST_IDLE: begin
        if (!rx_sync_q) begin
          state_d = ST_START;
          div_d   = clkdiv_q;
          cnt_d   = clkdiv_q >> 1;
        end
      end
      ST_START: begin
        if (expire_c) begin
          if (rx_sync_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            bit_d   = 3'd0;
            cnt_d   = div_q;
          end
        end
      end
      ST_DATA: begin
        if (expire_c) begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = 3'(bit_q + 3'd1);
          cnt_d   = div_q;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (expire_c) begin
          parity_set_c = rx_sync_q ^ (^shift_q);
          cnt_d        = div_q;
          state_d      = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (expire_c) begin
          state_d = ST_IDLE;
          if (rx_sync_q) begin
            // A same-cycle pop frees a slot even when full
            if (!full_c || pop_c) push_c = 1'b1;
            else                  overrun_set_c = 1'b1;
          end else begin
            frame_set_c = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO storage (no reset needed: reads are masked when empty)
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= shift_q;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= PTR_W'(wr_ptr_q + PTR_W'(1));
      if (pop_c)  rd_ptr_q <= PTR_W'(rd_ptr_q + PTR_W'(1));
      case ({push_c, pop_c})
        2'b10:   count_q <= CNT_W'(count_q + CNT_W'(1));
        2'b01:   count_q <= CNT_W'(count_q - CNT_W'(1));
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky flags (set beats W1C), baud divisor and interrupt
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_q <= 1'b0;
      frame_q   <= 1'b0;
      parity_q  <= 1'b0;
      clkdiv_q  <= BUS_WIDTH'(CLKS_PER_BIT);
      irq_q     <= 1'b0;
    end else begin
      overrun_q <= overrun_set_c | (overrun_q & ~(w1c_c & S_PWDATA[2]));
      frame_q   <= frame_set_c   | (frame_q   & ~(w1c_c & S_PWDATA[3]));
      parity_q  <= parity_set_c  | (parity_q  & ~(w1c_c & S_PWDATA[4]));
      if (clkdiv_wr_c)
        clkdiv_q <= (S_PWDATA < BUS_WIDTH'(MIN_DIV)) ? BUS_WIDTH'(MIN_DIV) : S_PWDATA;
      irq_q     <= not_empty_c;
    end
  end

  assign irq = irq_q;

  assign status_c = {8'(count_q), 3'b000, parity_q, frame_q, overrun_q, full_c, not_empty_c};

  // Read mux
  always_comb begin
    rdata_c = '0;
    case (addr_c)
      2'd0:    if (not_empty_c) rdata_c = BUS_WIDTH'(mem_q[rd_ptr_q]);
      2'd1:    rdata_c = BUS_WIDTH'(status_c);
      2'd2:    rdata_c = clkdiv_q;
      default: rdata_c = '0;
    endcase
  end

  // Shared bus lines are released when not selected
  assign S_PRDATA = S_PSELx ? rdata_c : {BUS_WIDTH{1'bz}};
  assign S_PREADY = S_PSELx ? 1'b1 : 1'bz;

endmodule
